mp_add_seq: RTL

- Multi-word (multi-precision) add sequencer built around one shared adder_nbit instance.
- Accepts NUM_WORDS operand word pairs, least significant word first, over a valid/ready stream.
- Chains the carry between words through a register and streams the sum words out with backpressure.
- Reports the final carry. Lets the datapath add operands of NUM_WORDS*BIT_WIDTH bits using a single BIT_WIDTH adder.

---
 rtl/mp_add_pkg.sv | 13 +
 rtl/mp_add_seq_if.sv | 39 +++
 rtl/adder_nbit.sv | 21 ++
 rtl/mp_add_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// rtl/mp_add_pkg.sv - shared types for the multi-word add sequencer
//
// Purpose: sequencer FSM state encoding shared by the sequencer and its bench.
// Ports: none (package).
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mp_add_seq_if.sv
// rtl/mp_add_seq_if.sv - control, operand stream and sum stream bundle
//
// Purpose: groups the sequencer's control, input word stream and output word
//          stream so the top and its driver connect through modports.
// Signals:
//   start, carry_init         control into the sequencer
//   in_valid/in_ready         operand handshake, a_word/b_word payload
//   out_valid/out_ready       sum handshake, sum_word/out_last payload
//   carry_out, busy, done     status out of the sequencer
// Modports: master = driver side, slave = sequencer side.
interface mp_add_seq_if #(
  parameter int BIT_WIDTH = 8
);

  logic                 start;
  logic                 carry_init;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] a_word;
  logic [BIT_WIDTH-1:0] b_word;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_WIDTH-1:0] sum_word;
  logic                 out_last;
  logic                 carry_out;
  logic                 busy;
  logic                 done;

  modport master (
    output start, carry_init, in_valid, a_word, b_word, out_ready,
    input  in_ready, out_valid, sum_word, out_last, carry_out, busy, done
  );

  modport slave (
    input  start, carry_init, in_valid, a_word, b_word, out_ready,
    output in_ready, out_valid, sum_word, out_last, carry_out, busy, done
  );

endinterface

// File: rtl/adder_nbit.sv
// rtl/adder_nbit.sv - combinational BIT_WIDTH adder with carry in/out
//
// Purpose: unsigned sum = a + b + cin modulo 2^BIT_WIDTH, cout = overflow.
// Ports:
//   a, b   in  BIT_WIDTH  operands
//   cin    in  1          carry in
//   sum    out BIT_WIDTH  sum word
//   cout   out 1          carry out
module adder_nbit #(
  parameter int BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-word add sequencer around one shared adder
//
// Purpose: adds two NUM_WORDS*BIT_WIDTH operands presented LSW first, one word
//          pair per accepted beat, chaining the carry through a register and
//          streaming registered sum words out with backpressure.
// Ports:
//   clk  in  1  system clock, rising edge
//   rst  in  1  synchronous active-high reset
//   bus  mp_add_seq_if.slave  control, operand stream, sum stream, status
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int  BIT_WIDTH = 8,
  parameter int  NUM_WORDS = 4,
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input logic        clk,
  input logic        rst,
  mp_add_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     count;
  logic                 carry_reg;
  logic [BIT_WIDTH-1:0] sum_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 carry_out_q;
  logic                 done_q;
  logic [BIT_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic                 in_ready;
  logic                 accept;
  logic                 out_fire;

  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_adder (
    .a    (bus.a_word),
    .b    (bus.b_word),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_ovf)
  );

  // Single output register: a new word may enter only if the slot is empty
  // or is being emptied this very cycle.
  assign in_ready = (state == RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (accept && (count == LAST_IDX)) state_next = DRAIN;
      DRAIN:   if (out_fire && out_last_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      carry_reg   <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            carry_reg   <= bus.carry_init;
            count       <= '0;
            carry_out_q <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            sum_q       <= add_sum;
            carry_reg   <= add_ovf;
            out_valid_q <= 1'b1;
            out_last_q  <= (count == LAST_IDX);
            count       <= count + CNT_W'(1);
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          // Only the last word can be pending here; its hand-off ends the op.
          if (out_fire && out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            carry_out_q <= carry_reg;
            done_q      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_word  = sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.carry_out = carry_out_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule
